demux_router: RTL

DEMUX_ROUTER -- requirements
Module: demux_router

---
 rtl/demux_pkg.sv | 28 ++
 rtl/demux_fifo2.sv | 81 ++++++++
 rtl/demux_router.sv | 96 +++++++++
 3 files changed

// File: rtl/demux_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_pkg : shared defaults and buffer-occupancy encoding for the router |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package demux_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF  = 2;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } buf_state_e;

    function automatic buf_state_e buf_state(input int unsigned count, input int unsigned depth);
        if (count == 0) begin
            return EMPTY;
        end
        if (count >= depth) begin
            return FULL;
        end
        return PARTIAL;
    endfunction

endpackage
`default_nettype wire

// File: rtl/demux_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_fifo2 : DEPTH-entry output buffer, async active-low reset          |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module demux_fifo2
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  last_ptr;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              do_push, do_pop;
    buf_state_e        state;

    always_comb begin
        state   = buf_state(32'(count_q), DEPTH);
        full_o  = (state == FULL);
        empty_o = (state == EMPTY);
        do_push = push_i & ~full_o;
        do_pop  = pop_i & ~empty_o;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
            end
        end
    end

    // When drained, the slot behind the read pointer still holds the last head byte.
    assign last_ptr = rd_ptr_q - PTR_W'(1);
    assign data_o   = empty_o ? mem_q[last_ptr] : mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: rtl/demux_router.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | demux_router : 1-to-2 byte demultiplexer with buffered outputs           |
// | Optional delivery counters enabled by macro DEMUX_COUNT_EN. Rev 1.0      |
// +--------------------------------------------------------------------------+
module demux_router
    import demux_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              Clock,
    input  logic              Clear_n,
    input  logic              Control,
    input  logic [DATA_W-1:0] in_data,
    input  logic              In_Valid,
    output logic              In_Ready,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic              Out0_Valid,
    output logic              Out1_Valid,
    input  logic              Out0_Ready,
    input  logic              Out1_Ready
`ifdef DEMUX_COUNT_EN
    ,
    output logic [7:0]        Count0,
    output logic [7:0]        Count1
`endif
);

    logic full0, full1, empty0, empty1;
    logic accept, push0, push1, pop0, pop1;

    // Readiness follows the live Control so a sink switch is seen the same cycle.
    always_comb begin
        In_Ready   = Clear_n & (Control ? ~full1 : ~full0);
        accept     = In_Valid & In_Ready;
        push0      = accept & ~Control;
        push1      = accept & Control;
        Out0_Valid = ~empty0;
        Out1_Valid = ~empty1;
        pop0       = Out0_Valid & Out0_Ready;
        pop1       = Out1_Valid & Out1_Ready;
    end

    demux_fifo2 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo0 (
        .clk_i   (Clock),
        .rst_ni  (Clear_n),
        .push_i  (push0),
        .pop_i   (pop0),
        .data_i  (in_data),
        .data_o  (out0),
        .full_o  (full0),
        .empty_o (empty0)
    );

    demux_fifo2 #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo1 (
        .clk_i   (Clock),
        .rst_ni  (Clear_n),
        .push_i  (push1),
        .pop_i   (pop1),
        .data_i  (in_data),
        .data_o  (out1),
        .full_o  (full1),
        .empty_o (empty1)
    );

`ifdef DEMUX_COUNT_EN
    logic [7:0] count0_q, count1_q;

    always_ff @(posedge Clock or negedge Clear_n) begin
        if (!Clear_n) begin
            count0_q <= 8'd0;
            count1_q <= 8'd0;
        end else begin
            if (pop0) begin
                count0_q <= count0_q + 8'd1;
            end
            if (pop1) begin
                count1_q <= count1_q + 8'd1;
            end
        end
    end

    assign Count0 = count0_q;
    assign Count1 = count1_q;
`endif

endmodule
`default_nettype wire
